// File: rtl/diff_to_bcd_seq_pkg.sv
// Shared definitions for the signed binary-to-BCD converter: FSM state
// encoding, BCD digit width and the double-dabble correction constants.
package diff_to_bcd_seq_pkg;

    localparam int DIGIT_W = 4;

    // A digit of 5 or more doubles past 9, so it is pre-corrected by 3.
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/diff_to_bcd_seq_bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module diff_to_bcd_seq_bcd_add3
    import diff_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Working digits never exceed 9 here, so the sum always fits in 4 bits.
    assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + ADD3_OFFSET : digit_i;

endmodule

// File: rtl/diff_to_bcd_seq.sv
// Sequential signed binary-to-BCD converter. Accepts a two's-complement
// value, converts its magnitude one bit per clock with shift-add-3, and
// presents sign plus three BCD digits with a one-cycle out_valid pulse.
// W is legal from 4 to 9 so the magnitude (at most 256) fits three digits.
module diff_to_bcd_seq
    import diff_to_bcd_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    output logic                NEG,
    output logic [DIGIT_W-1:0]  ONES,
    output logic [DIGIT_W-1:0]  TENS,
    output logic [DIGIT_W-1:0]  HUNDREDS
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam int SW = 3 * DIGIT_W + W;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [W-1:0]         mag_q;
    logic                 sign_q;
    logic [DIGIT_W-1:0]   ones_q, tens_q, hund_q;

    logic                 out_valid_q;
    logic                 neg_out_q;
    logic [DIGIT_W-1:0]   ones_out_q, tens_out_q, hund_out_q;

    logic [DIGIT_W-1:0]   ones_c, tens_c, hund_c;
    logic [SW-1:0]        work_sh;
    logic [DIGIT_W-1:0]   ones_d, tens_d, hund_d;
    logic [W-1:0]         mag_d;
    logic [W-1:0]         neg_mag;

    // Magnitude of a negative input; -2^(W-1) wraps to 2^(W-1) as unsigned.
    assign neg_mag = W'(0) - in_data;

    diff_to_bcd_seq_bcd_add3 u_add3_ones (.digit_i(ones_q), .digit_o(ones_c));
    diff_to_bcd_seq_bcd_add3 u_add3_tens (.digit_i(tens_q), .digit_o(tens_c));
    diff_to_bcd_seq_bcd_add3 u_add3_hund (.digit_i(hund_q), .digit_o(hund_c));

    // One double-dabble step: corrected digits and magnitude shifted left as one word.
    assign work_sh = {hund_c, tens_c, ones_c, mag_q} << 1;
    assign hund_d  = work_sh[SW-1 -: DIGIT_W];
    assign tens_d  = work_sh[SW-1-DIGIT_W -: DIGIT_W];
    assign ones_d  = work_sh[W +: DIGIT_W];
    assign mag_d   = work_sh[W-1:0];

    // Ready only when idle and not held in reset.
    assign in_ready = (state_q == ST_IDLE) && !RESET;

    assign out_valid = out_valid_q;
    assign NEG       = neg_out_q;
    assign ONES      = ones_out_q;
    assign TENS      = tens_out_q;
    assign HUNDREDS  = hund_out_q;

    // Conversion FSM: capture in IDLE, W shift steps, publish result in DONE.
    // NOTE: every register here is assigned with <= so all of them update
    // together from the values seen before the edge.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            ones_q      <= '0;
            tens_q      <= '0;
            hund_q      <= '0;
            out_valid_q <= 1'b0;
            neg_out_q   <= 1'b0;
            ones_out_q  <= '0;
            tens_out_q  <= '0;
            hund_out_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_data[W-1];
                        mag_q   <= in_data[W-1] ? neg_mag : in_data;
                        ones_q  <= '0;
                        tens_q  <= '0;
                        hund_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    hund_q <= hund_d;
                    tens_q <= tens_d;
                    ones_q <= ones_d;
                    mag_q  <= mag_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A zero magnitude never shows as negative; the sign bit of
                    // zero is already 0, so the captured sign is used directly.
                    neg_out_q   <= sign_q;
                    ones_out_q  <= ones_q;
                    tens_out_q  <= tens_q;
                    hund_out_q  <= hund_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
